// File: rtl/tl_pkg.sv
// Shared LED encodings and phase codes for the intersection sequencer.
package tl_pkg;

    localparam logic [2:0] LED_GRN = 3'b110;
    localparam logic [2:0] LED_RED = 3'b101;
    localparam logic [2:0] LED_AMB = 3'b011;
    localparam logic [2:0] LED_OFF = 3'b111;

    typedef enum logic [2:0] {
        ALLRED_B = 3'd0,
        MAIN_GO  = 3'd1,
        MAIN_AMB = 3'd2,
        ALLRED_A = 3'd3,
        SIDE_GO  = 3'd4,
        SIDE_AMB = 3'd5,
        PED_WALK = 3'd6
    } state_t;

endpackage

// File: rtl/sec_tick.sv
// Divides sys_clk down to a one-cycle strobe per second.
module sec_tick #(
    parameter int TICK_DIV = 24000000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] div;

    assign tick = (div == LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div <= '0;
        end else if (clr || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/intersection_sequencer.sv
// Main/side/pedestrian phase sequencer with request arbitration
// and registered active-low LED head outputs.
module intersection_sequencer
    import tl_pkg::*;
#(
    parameter int TICK_DIV = 24000000,
    parameter int MAIN_MIN = 10,
    parameter int SIDE_GRN = 5,
    parameter int AMBER_T  = 3,
    parameter int ALLRED_T = 1,
    parameter int WALK_T   = 5
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_led,
    output logic [2:0] side_led,
    output logic       ped_walk,
    output logic [2:0] phase
);

    localparam logic [7:0] MAIN_LIM = 8'(MAIN_MIN - 1);
    localparam logic [7:0] SIDE_LIM = 8'(SIDE_GRN - 1);
    localparam logic [7:0] AMB_LIM  = 8'(AMBER_T - 1);
    localparam logic [7:0] ARED_LIM = 8'(ALLRED_T - 1);
    localparam logic [7:0] WALK_LIM = 8'(WALK_T - 1);

    state_t     state;
    state_t     nx;
    logic       enter;
    logic       tick;
    logic [7:0] secs;
    logic       side_s1, side_s2;
    logic       ped_s1, ped_s2, ped_q;
    logic       side_pend, ped_pend, from_side;
    logic [2:0] main_nx, side_nx;
    logic       walk_nx;

    assign enter = (nx != state);

    sec_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (enter),
        .tick      (tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            side_s1 <= 1'b0;
            side_s2 <= 1'b0;
            ped_s1  <= 1'b0;
            ped_s2  <= 1'b0;
            ped_q   <= 1'b0;
        end else begin
            side_s1 <= side_req;
            side_s2 <= side_s1;
            ped_s1  <= ped_req;
            ped_s2  <= ped_s1;
            ped_q   <= ped_s2;
        end
    end

    // Seconds elapsed in the current phase; saturates rather than wraps.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            secs <= '0;
        end else if (enter) begin
            secs <= '0;
        end else if (tick && secs != 8'hFF) begin
            secs <= secs + 8'd1;
        end
    end

    always_comb begin
        nx = state;
        case (state)
            ALLRED_B: if (tick && secs == ARED_LIM)
                nx = (from_side && ped_pend) ? PED_WALK : MAIN_GO;
            MAIN_GO: if (tick && secs >= MAIN_LIM && (side_pend || ped_pend))
                nx = MAIN_AMB;
            MAIN_AMB: if (tick && secs == AMB_LIM)
                nx = ALLRED_A;
            ALLRED_A: if (tick && secs == ARED_LIM)
                nx = side_pend ? SIDE_GO : PED_WALK;
            SIDE_GO: if (tick && secs == SIDE_LIM)
                nx = SIDE_AMB;
            SIDE_AMB: if (tick && secs == AMB_LIM)
                nx = ALLRED_B;
            PED_WALK: if (tick && secs == WALK_LIM)
                nx = ALLRED_B;
            default: nx = ALLRED_B;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        main_nx = LED_RED;
        side_nx = LED_RED;
        walk_nx = 1'b0;
        case (nx)
            ALLRED_B, ALLRED_A: ;
            MAIN_GO:  main_nx = LED_GRN;
            MAIN_AMB: main_nx = LED_AMB;
            SIDE_GO:  side_nx = LED_GRN;
            SIDE_AMB: side_nx = LED_AMB;
            PED_WALK: walk_nx = 1'b1;
            default: begin
                main_nx = LED_OFF;
                side_nx = LED_OFF;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ALLRED_B;
            main_led <= LED_RED;
            side_led <= LED_RED;
            ped_walk <= 1'b0;
            phase    <= 3'd0;
        end else begin
            state    <= nx;
            main_led <= main_nx;
            side_led <= side_nx;
            ped_walk <= walk_nx;
            phase    <= nx;
        end
    end

    // A clear on entry into the serving phase wins over a same-cycle set.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            side_pend <= 1'b0;
            ped_pend  <= 1'b0;
            from_side <= 1'b0;
        end else begin
            if (enter && nx == SIDE_GO) side_pend <= 1'b0;
            else if (side_s2)           side_pend <= 1'b1;
            if (enter && nx == PED_WALK)  ped_pend <= 1'b0;
            else if (ped_s2 && !ped_q)    ped_pend <= 1'b1;
            if (enter) begin
                if (state == SIDE_AMB)
                    from_side <= 1'b1;
                else if (state == PED_WALK || nx == MAIN_GO)
                    from_side <= 1'b0;
            end
        end
    end

endmodule
